// File: rtl/libmemif_pkg.sv
// rtl/libmemif_pkg.sv - shared DRAM user-interface widths, responder states and err bit indices
package libmemif_pkg;

    localparam int DRAM_ADDR_W = 28;
    localparam int DRAM_DATA_W = 144;
    localparam int DRAM_CORE_W = 128;
    localparam int DRAM_BEATS  = 2;

    localparam int ERR_AF_OVF = 0;
    localparam int ERR_WB_OVF = 1;
    localparam int ERR_RB_UDF = 2;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BEAT0,
        ST_RD_BEAT1,
        ST_WR_BEAT0,
        ST_WR_BEAT1
    } dram_resp_state_t;

endpackage

// File: rtl/dram_ui_fifo.sv
// rtl/dram_ui_fifo.sv - first-word-fall-through FIFO with slack-based full and overflow/underflow strobes
module dram_ui_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int SLACK = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = next_ptr(wr_q);
        if (do_pop)  rd_d = next_ptr(rd_q);
        if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Head is forced to zero when empty so the output is clean straight out of reset.
    assign dout      = (cnt_q == '0) ? '0 : mem_q[rd_q];
    assign count     = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q >= CW'(DEPTH - SLACK));
    assign overflow  = push && (cnt_q == CW'(DEPTH));
    assign underflow = pop && (cnt_q == '0);

endmodule

// File: rtl/dram_ui_responder.sv
// rtl/dram_ui_responder.sv - in-order AF/WB/RB DRAM UI slave over a BRAM line store; DRAM_UI_RESP_ECC_BITS_EN keeps bits [143:128]
module dram_ui_responder
    import libmemif_pkg::*;
#(
    parameter int AF_DEPTH = 8,
    parameter int WB_DEPTH = 8,
    parameter int RB_DEPTH = 8,
    parameter int SLACK    = 2,
    parameter int MEM_AW   = 10,
    parameter int RD_LAT   = 4
) (
    input  iu_clk_type             gclk,
    input  logic                   rstn,
    input  logic [DRAM_ADDR_W-1:0] Address,
    input  logic                   Read,
    input  logic                   WriteAF,
    output logic                   AFfull,
    input  logic [DRAM_DATA_W-1:0] WriteData,
    input  logic                   WriteWB,
    output logic                   WBfull,
    output logic [DRAM_DATA_W-1:0] ReadData,
    input  logic                   ReadRB,
    output logic                   RBempty,
    output logic                   RBfull,
    output logic [2:0]             err
);

`ifdef DRAM_UI_RESP_ECC_BITS_EN
    localparam int ARR_W = DRAM_DATA_W;
`else
    localparam int ARR_W = DRAM_CORE_W;
`endif
    localparam int AF_W  = MEM_AW + 1;
    localparam int AF_CW = $clog2(AF_DEPTH + 1);
    localparam int WB_CW = $clog2(WB_DEPTH + 1);
    localparam int RB_CW = $clog2(RB_DEPTH + 1);

    logic clk;
    assign clk = gclk.clk;

    logic [AF_W-1:0]  af_dout;
    logic [AF_CW-1:0] af_count;
    logic             af_empty, af_pop, af_ovf, af_udf;
    logic [ARR_W-1:0] wb_dout;
    logic [WB_CW-1:0] wb_count;
    logic             wb_empty, wb_pop, wb_ovf, wb_udf;
    logic [ARR_W-1:0] rb_dout;
    logic [RB_CW-1:0] rb_count;
    logic             rb_ovf, rb_udf;

    dram_resp_state_t  state_q, state_d;
    logic [MEM_AW-1:0] line_q, line_d;
    logic [3:0]        wait_q, wait_d;
    logic [RB_CW-1:0]  resv_q, resv_d;
    logic [2:0]        err_q, err_d;
    logic              rd_push_q;
    logic [ARR_W-1:0]  rdata_q;

    logic              arr_re, arr_we, resv_add, rb_room;
    logic [MEM_AW:0]   arr_addr;
    logic [ARR_W-1:0]  mem_q [2**(MEM_AW+1)];

    logic unused_bits;
`ifdef DRAM_UI_RESP_ECC_BITS_EN
    assign unused_bits = ^{Address[DRAM_ADDR_W-1:MEM_AW], af_count, wb_empty, wb_udf, rb_ovf};
`else
    assign unused_bits = ^{Address[DRAM_ADDR_W-1:MEM_AW], WriteData[DRAM_DATA_W-1:ARR_W],
                           af_count, wb_empty, wb_udf, rb_ovf};
`endif

    dram_ui_fifo #(.W(AF_W), .DEPTH(AF_DEPTH), .SLACK(SLACK)) u_af (
        .clk(clk), .rstn(rstn),
        .push(WriteAF), .din({Read, Address[MEM_AW-1:0]}),
        .pop(af_pop), .dout(af_dout), .count(af_count),
        .full(AFfull), .empty(af_empty), .overflow(af_ovf), .underflow(af_udf)
    );

    dram_ui_fifo #(.W(ARR_W), .DEPTH(WB_DEPTH), .SLACK(SLACK)) u_wb (
        .clk(clk), .rstn(rstn),
        .push(WriteWB), .din(WriteData[ARR_W-1:0]),
        .pop(wb_pop), .dout(wb_dout), .count(wb_count),
        .full(WBfull), .empty(wb_empty), .overflow(wb_ovf), .underflow(wb_udf)
    );

    dram_ui_fifo #(.W(ARR_W), .DEPTH(RB_DEPTH), .SLACK(SLACK)) u_rb (
        .clk(clk), .rstn(rstn),
        .push(rd_push_q), .din(rdata_q),
        .pop(ReadRB), .dout(rb_dout), .count(rb_count),
        .full(RBfull), .empty(RBempty), .overflow(rb_ovf), .underflow(rb_udf)
    );

    // A read is only accepted when both of its beats are guaranteed a slot,
    // counting beats of earlier reads that are still in flight.
    assign rb_room = ({1'b0, rb_count} + {1'b0, resv_q}) <= (RB_CW + 1)'(RB_DEPTH - DRAM_BEATS);

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        wait_d   = wait_q;
        af_pop   = 1'b0;
        wb_pop   = 1'b0;
        arr_re   = 1'b0;
        arr_we   = 1'b0;
        resv_add = 1'b0;
        arr_addr = {line_q, 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (!af_empty) begin
                    if (af_dout[MEM_AW]) begin
                        if (rb_room) begin
                            af_pop   = 1'b1;
                            resv_add = 1'b1;
                            line_d   = af_dout[MEM_AW-1:0];
                            if (RD_LAT > 0) begin
                                state_d = ST_RD_WAIT;
                                wait_d  = 4'(RD_LAT - 1);
                            end else begin
                                state_d = ST_RD_BEAT0;
                            end
                        end
                    end else if (wb_count >= WB_CW'(DRAM_BEATS)) begin
                        af_pop  = 1'b1;
                        line_d  = af_dout[MEM_AW-1:0];
                        state_d = ST_WR_BEAT0;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == 4'd0) state_d = ST_RD_BEAT0;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_RD_BEAT0: begin
                arr_re  = 1'b1;
                state_d = ST_RD_BEAT1;
            end
            ST_RD_BEAT1: begin
                arr_re   = 1'b1;
                arr_addr = {line_q, 1'b1};
                state_d  = ST_IDLE;
            end
            ST_WR_BEAT0: begin
                arr_we  = 1'b1;
                wb_pop  = 1'b1;
                state_d = ST_WR_BEAT1;
            end
            ST_WR_BEAT1: begin
                arr_we   = 1'b1;
                wb_pop   = 1'b1;
                arr_addr = {line_q, 1'b1};
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resv_d = resv_q;
        if (resv_add)  resv_d = resv_d + RB_CW'(DRAM_BEATS);
        if (rd_push_q) resv_d = resv_d - RB_CW'(1);
        err_d = err_q;
        if (af_ovf) err_d[ERR_AF_OVF] = 1'b1;
        if (wb_ovf) err_d[ERR_WB_OVF] = 1'b1;
        if (rb_udf) err_d[ERR_RB_UDF] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            wait_q    <= '0;
            resv_q    <= '0;
            err_q     <= '0;
            rd_push_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            wait_q    <= wait_d;
            resv_q    <= resv_d;
            err_q     <= err_d;
            rd_push_q <= arr_re;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) mem_q[arr_addr] <= wb_dout;
        if (arr_re) rdata_q <= mem_q[arr_addr];
    end

`ifdef DRAM_UI_RESP_ECC_BITS_EN
    assign ReadData = rb_dout;
`else
    assign ReadData = {16'h0, rb_dout};
`endif
    assign err = err_q;

endmodule

// File: tb/tb_dram_ui_responder.sv
// tb/tb_dram_ui_responder.sv - directed scoreboard bench for dram_ui_responder
module tb_dram_ui_responder;
    import libmemif_pkg::*;

    logic        clk = 1'b0;
    iu_clk_type  gclk;
    logic        rstn;
    logic [27:0] Address;
    logic        Read, WriteAF, WriteWB, ReadRB;
    logic [143:0] WriteData;
    logic        AFfull, WBfull, RBempty, RBfull;
    logic [143:0] ReadData;
    logic [2:0]  err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [143:0] sb [$];
    logic [143:0] model [int];

    assign gclk.clk = clk;
    always #5 clk = ~clk;

    dram_ui_responder dut (
        .gclk(gclk), .rstn(rstn),
        .Address(Address), .Read(Read), .WriteAF(WriteAF), .AFfull(AFfull),
        .WriteData(WriteData), .WriteWB(WriteWB), .WBfull(WBfull),
        .ReadData(ReadData), .ReadRB(ReadRB), .RBempty(RBempty), .RBfull(RBfull),
        .err(err)
    );

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] exp_of(input logic [143:0] d);
`ifdef DRAM_UI_RESP_ECC_BITS_EN
        return d;
`else
        return {16'h0, d[127:0]};
`endif
    endfunction

    function automatic int key(input logic [27:0] a, input int beat);
        return int'(a[9:0]) * 2 + beat;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [27:0] a, input logic rd);
        Address = a;
        Read    = rd;
        WriteAF = 1'b1;
        cycle();
        WriteAF = 1'b0;
    endtask

    task automatic send_wb(input logic [127:0] d, output logic [143:0] full);
        full      = {16'($urandom), d};
        WriteData = full;
        WriteWB   = 1'b1;
        cycle();
        WriteWB   = 1'b0;
    endtask

    task automatic write_line(input logic [27:0] a, input logic [127:0] d0, input logic [127:0] d1);
        logic [143:0] f0, f1;
        send_wb(d0, f0);
        send_wb(d1, f1);
        send_cmd(a, 1'b0);
        model[key(a, 0)] = exp_of(f0);
        model[key(a, 1)] = exp_of(f1);
    endtask

    task automatic read_line(input logic [27:0] a);
        send_cmd(a, 1'b1);
        sb.push_back(model[key(a, 0)]);
        sb.push_back(model[key(a, 1)]);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            int t = 0;
            while (RBempty && t < 200) begin
                cycle();
                t++;
            end
            if (RBempty) begin
                check("rb_timeout", {143'h0, RBempty}, 144'h0);
                sb.delete();
            end else begin
                check("rb_data", ReadData, sb.pop_front());
                ReadRB = 1'b1;
                cycle();
                ReadRB = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
        cycle();
    endtask

    initial begin
        logic [143:0] f0, f1;
        rstn = 1'b0;
        Address = '0; Read = 1'b0; WriteAF = 1'b0;
        WriteData = '0; WriteWB = 1'b0; ReadRB = 1'b0;
        repeat (3) cycle();
        check("rst_rbempty", {143'h0, RBempty}, 144'h1);
        check("rst_afull", {143'h0, AFfull}, 144'h0);
        check("rst_wbfull", {143'h0, WBfull}, 144'h0);
        check("rst_rbfull", {143'h0, RBfull}, 144'h0);
        check("rst_rdata", ReadData, 144'h0);
        check("rst_err", {141'h0, err}, 144'h0);
        rstn = 1'b1;
        repeat (2) cycle();

        // write then read with RD_LAT=4: empty must fall 8 cycles after the read's WriteAF
        write_line(28'h5, {32{4'hA}}, {32{4'hB}});
        repeat (8) cycle();
        read_line(28'h5);
        repeat (6) cycle();
        check("lat_before", {143'h0, RBempty}, 144'h1);
        cycle();
        check("lat_at", {143'h0, RBempty}, 144'h0);
        drain();

        // write with a single beat stalls until the second beat arrives
        send_wb({32{4'h3}}, f0);
        send_cmd(28'h12, 1'b0);
        repeat (20) cycle();
        check("onebeat_stall_err", {141'h0, err}, 144'h0);
        check("onebeat_stall_wbfull", {143'h0, WBfull}, 144'h0);
        send_wb({32{4'h4}}, f1);
        model[key(28'h12, 0)] = exp_of(f0);
        model[key(28'h12, 1)] = exp_of(f1);
        read_line(28'h12);
        drain();

        // address bits above MEM_AW alias
        write_line(28'h0000400, {32{4'hC}}, {32{4'hD}});
        read_line(28'h0000000);
        drain();

        // back-pressure: eight reads with ReadRB held low
        write_line(28'h77, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h5a5a_0000_ffff_1111_2222_3333_4444_5555);
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: read_line(28'h5);
                1: read_line(28'h12);
                2: read_line(28'h0);
                default: read_line(28'h77);
            endcase
        end
        repeat (100) cycle();
        check("bp_rbfull", {143'h0, RBfull}, 144'h1);
        check("bp_rbempty", {143'h0, RBempty}, 144'h0);
        check("bp_afull", {143'h0, AFfull}, 144'h0);
        drain();
        check("bp_err", {141'h0, err}, 144'h0);

        // AF overflow with FSM stalled on a write that has no WB data
        for (int i = 1; i <= 9; i++) begin
            send_cmd(28'h30, 1'b0);
            if (i == 5) check("af_5_full", {143'h0, AFfull}, 144'h0);
            if (i == 6) check("af_6_full", {143'h0, AFfull}, 144'h1);
            if (i == 8) check("af_8_err", {141'h0, err}, 144'h0);
            if (i == 9) check("af_9_err", {141'h0, err}, 144'h1);
        end
        repeat (10) cycle();
        check("af_err_sticky", {141'h0, err}, 144'h1);
        pulse_reset();
        check("af_rst_err", {141'h0, err}, 144'h0);
        check("af_rst_full", {143'h0, AFfull}, 144'h0);

        // RB underflow
        ReadRB = 1'b1;
        cycle();
        ReadRB = 1'b0;
        check("rb_udf_err", {141'h0, err}, 144'h4);
        check("rb_udf_rdata", ReadData, 144'h0);
        pulse_reset();

        // reset while a read sits in RD_WAIT
        send_cmd(28'h5, 1'b1);
        repeat (2) cycle();
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_rbempty", {143'h0, RBempty}, 144'h1);
        repeat (3) cycle();
        rstn = 1'b1;
        repeat (20) cycle();
        check("midrst_rbempty_after", {143'h0, RBempty}, 144'h1);
        check("midrst_rdata", ReadData, 144'h0);
        check("midrst_err", {141'h0, err}, 144'h0);
        check("midrst_flags", {141'h0, AFfull, WBfull, RBfull}, 144'h0);

        // store survives reset and normal operation resumes
        read_line(28'h77);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dram_ui_responder.md
Name: dram_ui_responder

Overview:
- Slave-side model of the DRAM controller user interface: the address FIFO (AF), write buffer (WB) and read buffer (RB) ports that the memory adapter drives.
- Services commands in order against a BRAM line store. Each line is 2 beats of 128 bits.
- Replaces the MIG controller in simulation and in small FPGA builds with no DRAM.
- Sits directly under the mem_controller_interface dram modport.

Parameters:
- AF_DEPTH, 8: address FIFO entries.
- WB_DEPTH, 8: write buffer entries (beats).
- RB_DEPTH, 8: read buffer entries (beats).
- SLACK, 2: free-entry threshold at which AFfull/WBfull/RBfull assert. Covers the requester's registered full flags.
- MEM_AW, 10: line-index width; the store holds 2^MEM_AW lines.
- RD_LAT, 4: extra wait cycles before a read accesses the array. Range 0..15.

Ports:
- gclk, input, iu_clk_type: only gclk.clk is used. AFclock/WBclock/RBclock are tied to gclk.clk by the integrator and are not ports.
- rstn, input, 1: asynchronous active-low reset.
- Address, input, 28: command address; line index = Address[MEM_AW-1:0].
- Read, input, 1: 1 = read, 0 = write.
- WriteAF, input, 1: AF push.
- AFfull, output, 1: AF free entries <= SLACK.
- WriteData, input, 144: write beat.
- WriteWB, input, 1: WB push.
- WBfull, output, 1: WB free entries <= SLACK.
- ReadData, output, 144: RB head, first-word-fall-through.
- ReadRB, input, 1: RB pop.
- RBempty, output, 1: RB count == 0.
- RBfull, output, 1: RB free entries <= SLACK.
- err, output, 3: sticky flags. [0] AF overflow, [1] WB overflow, [2] RB underflow.

Behaviour:
- Reset (async, rstn=0):
  - FIFOs emptied, FSM to IDLE, wait counter cleared.
  - RBempty=1; AFfull=WBfull=RBfull=0; ReadData=0; err=0.
  - Array contents are not reset.
  - An in-flight command is discarded and emits nothing after reset release.
- FIFOs:
  - Push occurs on push & count<DEPTH. Push while count==DEPTH drops the data and sets the matching err bit.
  - Simultaneous push+pop leaves count unchanged.
  - Pop while empty is ignored. ReadRB with RBempty=1 sets err[2].
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, RD_WAIT, RD_BEAT0, RD_BEAT1, WR_BEAT0, WR_BEAT1.
- IDLE, AF non-empty, head Read=1:
  - Requires RB free minus reserved >= 2.
  - If met: pop AF, latch the line, reserve 2 RB slots, then go to RD_WAIT (RD_LAT>0) or RD_BEAT0.
  - Otherwise stay in IDLE.
- IDLE, AF non-empty, head Read=0:
  - Requires WB count >= 2.
  - If met: pop AF, latch the line, go to WR_BEAT0. Otherwise stay in IDLE; there is no timeout.
- RD_WAIT: counts RD_LAT cycles, then RD_BEAT0.
- RD_BEAT0 / RD_BEAT1:
  - Present word {line,0} / {line,1} to the synchronous array.
  - Read data is pushed into RB one cycle later; each push releases one reservation.
  - RD_BEAT1 goes to IDLE.
- WR_BEAT0 / WR_BEAT1:
  - Write WB head [127:0] to {line,0} / {line,1} and pop WB.
  - WR_BEAT1 goes to IDLE.
- Ordering:
  - Strictly in order.
  - A read after a write to the same line returns the new data.
  - A write issued in the cycle after a read's RD_BEAT1 does not affect that read's data.
- Read latency: RBempty deasserts exactly RD_LAT+4 cycles after the WriteAF cycle when all queues are idle. Beat 1 follows one cycle later.
- Addresses: Address bits above MEM_AW alias.
- ReadData[143:128] = 0 and WriteData[143:128] is discarded, unless the optional feature is enabled.

Optional Feature:
- Macro: DRAM_UI_RESP_ECC_BITS_EN.
- Defined: the array is 144 bits wide; WriteData[143:128] is stored and returned on ReadData[143:128].
- Undefined: the array is 128 bits wide and ReadData[143:128] = 16'h0.

Decomposition:
- Shared in libmemif:
  - DRAM_ADDR_W=28, DRAM_DATA_W=144, DRAM_BEATS=2.
  - dram_resp_state_t enum.
  - err bit index constants.
- One sub-module, dram_ui_fifo (parameterised width/depth/SLACK, with full/empty/count outputs), instantiated for AF, WB and RB.

Test Plan:
- Write then read, RD_LAT=4:
  - Stimulus: write line 0x5 with beats 0xA..A, 0xB..B (2 WriteWB, 1 WriteAF), then read 0x5.
  - Response: RB gives {16'h0,0xA..A} then {16'h0,0xB..B}. RBempty falls 8 cycles after the read's WriteAF.
- Write with one beat:
  - Stimulus: write command plus one WB beat.
  - Response: FSM stays in IDLE with AF non-empty. The second beat triggers completion; a later read returns both beats.
- Back-pressure:
  - Stimulus: 8 reads with ReadRB=0.
  - Response: RBfull asserts at 6 RB entries and AFfull asserts at 6 AF entries. After ReadRB is raised, all 16 beats return in order and err=0.
- Overflow:
  - Stimulus: WriteAF on 9 consecutive cycles, AF_DEPTH=8, FSM stalled.
  - Response: 9th command is dropped and err[0]=1 until reset.
- Alias:
  - Stimulus: MEM_AW=10; write line 0x0000400, read line 0x0000000.
  - Response: the written data is returned.
- Reset mid-read:
  - Stimulus: rstn=0 during RD_WAIT.
  - Response: RBempty=1 immediately. After release nothing is pushed, and all outputs are at reset values.
